// File: rtl/wired_mdu_sched_if.sv
// Request, issue and writeback bundle between the two MDU requesters and wired_mdu_sched.
interface wired_mdu_sched_if #(
    parameter int TAG_W = 6
);
    // Handshake: request i transfers in a cycle where req_valid_i[i] && req_ready_o[i];
    // ready is combinational, may depend on valid, and a waiting requester holds its fields.
    logic [1:0]            req_valid_i;
    logic [1:0]            req_ready_o;
    logic [1:0]            req_is_div_i;
    logic [1:0][1:0]       req_op_i;
    logic [1:0][TAG_W-1:0] req_tag_i;
    logic [1:0]            req_div0_i;
    logic                  flush_i;
    logic                  mul_valid_o;
    logic                  mul_sel_o;
    logic [1:0]            mul_op_o;
    logic                  div_start_o;
    logic                  div_sel_o;
    logic [1:0]            div_op_o;
    logic                  div_abort_o;
    logic                  wb_valid_o;
    logic [TAG_W-1:0]      wb_tag_o;
    logic                  wb_src_o;
    logic [1:0]            div_state;

    modport master (
        output req_valid_i, req_is_div_i, req_op_i, req_tag_i, req_div0_i, flush_i,
        input  req_ready_o, mul_valid_o, mul_sel_o, mul_op_o, div_start_o, div_sel_o,
        input  div_op_o, div_abort_o, wb_valid_o, wb_tag_o, wb_src_o, div_state
    );

    modport slave (
        input  req_valid_i, req_is_div_i, req_op_i, req_tag_i, req_div0_i, flush_i,
        output req_ready_o, mul_valid_o, mul_sel_o, mul_op_o, div_start_o, div_sel_o,
        output div_op_o, div_abort_o, wb_valid_o, wb_tag_o, wb_src_o, div_state
    );
endinterface

// File: rtl/wired_mdu_sched.sv
// Two-requester scheduler for a shared multiplier pipeline and an iterative divider.
// Optional macro WIRED_MDU_DIV0_FAST_EN: divide-by-zero ops complete in a single cycle.
module wired_mdu_sched #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34,
    parameter int TAG_W   = 6
) (
    input logic clk,
    input logic rst,
    wired_mdu_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    div_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ptr;
    logic [1:0]         fast, elig, grant;
    logic               gnt_any, gnt_idx, gnt_div, gnt_fast, mul_block, div_done_nx;
    logic [MUL_LAT-1:0] stg_v;
    logic [TAG_W-1:0]   stg_tag [MUL_LAT];
    logic [TAG_W-1:0]   div_tag;
    logic               mul_valid, mul_sel, div_start, div_sel, div_abort;
    logic [1:0]         mul_op, div_op;
    logic               wb_valid, wb_src;
    logic [TAG_W-1:0]   wb_tag;

    always_comb begin
`ifdef WIRED_MDU_DIV0_FAST_EN
        fast = bus.req_div0_i;
`else
        fast = bus.req_div0_i & 2'b00;
`endif
        // A mul granted now writes back MUL_LAT+1 cycles later; that slot must not be the divider's DONE.
        mul_block = (state == BUSY) && (int'(cnt) == MUL_LAT);
        elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (bus.req_is_div_i[i])
                elig[i] = (state != BUSY) && !(fast[i] && stg_v[MUL_LAT-1]);
            else
                elig[i] = !mul_block;
            elig[i] = elig[i] && bus.req_valid_i[i] && !bus.flush_i && !rst;
        end
        if (elig == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
        else
            grant = elig;
        gnt_any  = |grant;
        gnt_idx  = grant[1];
        gnt_div  = gnt_any && bus.req_is_div_i[gnt_idx];
        gnt_fast = gnt_div && fast[gnt_idx];

        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, DONE: begin
                if (gnt_div) begin
                    state_nx = gnt_fast ? DONE : BUSY;
                    cnt_nx   = gnt_fast ? '0 : CNT_W'(DIV_LAT - 1);
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (cnt == '0)
                    state_nx = DONE;
                else
                    cnt_nx = cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.flush_i) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
        div_done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= 1'b0;
            stg_v     <= '0;
            for (int k = 0; k < MUL_LAT; k++) stg_tag[k] <= '0;
            div_tag   <= '0;
            mul_valid <= 1'b0;
            mul_sel   <= 1'b0;
            mul_op    <= 2'b00;
            div_start <= 1'b0;
            div_sel   <= 1'b0;
            div_op    <= 2'b00;
            div_abort <= 1'b0;
            wb_valid  <= 1'b0;
            wb_tag    <= '0;
            wb_src    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (gnt_any) ptr <= ~gnt_idx;
            mul_valid <= gnt_any && !gnt_div;
            if (gnt_any && !gnt_div) begin
                mul_sel <= gnt_idx;
                mul_op  <= bus.req_op_i[gnt_idx];
            end
            div_start <= gnt_div && !gnt_fast;
            if (gnt_div) begin
                div_sel <= gnt_idx;
                div_op  <= bus.req_op_i[gnt_idx];
                div_tag <= bus.req_tag_i[gnt_idx];
            end
            div_abort <= bus.flush_i && (state == BUSY);

            for (int k = MUL_LAT - 1; k > 0; k--) begin
                stg_v[k]   <= stg_v[k-1];
                stg_tag[k] <= stg_tag[k-1];
            end
            stg_v[0]   <= gnt_any && !gnt_div;
            stg_tag[0] <= bus.req_tag_i[gnt_idx];
            if (bus.flush_i) stg_v <= '0;

            // Collisions are prevented at grant time, so at most one source is live here.
            if (bus.flush_i) begin
                wb_valid <= 1'b0;
                wb_tag   <= '0;
                wb_src   <= 1'b0;
            end else if (div_done_nx) begin
                wb_valid <= 1'b1;
                wb_tag   <= gnt_fast ? bus.req_tag_i[gnt_idx] : div_tag;
                wb_src   <= 1'b1;
            end else if (stg_v[MUL_LAT-1]) begin
                wb_valid <= 1'b1;
                wb_tag   <= stg_tag[MUL_LAT-1];
                wb_src   <= 1'b0;
            end else begin
                wb_valid <= 1'b0;
                wb_tag   <= '0;
                wb_src   <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o = grant;
    assign bus.mul_valid_o = mul_valid;
    assign bus.mul_sel_o   = mul_sel;
    assign bus.mul_op_o    = mul_op;
    assign bus.div_start_o = div_start;
    assign bus.div_sel_o   = div_sel;
    assign bus.div_op_o    = div_op;
    assign bus.div_abort_o = div_abort;
    assign bus.wb_valid_o  = wb_valid;
    assign bus.wb_tag_o    = wb_tag;
    assign bus.wb_src_o    = wb_src;
    assign bus.div_state   = state;
endmodule
